// File: rtl/lsu_bus_initiator.sv
// LSU-side initiator of the femto req/resp bus: one bus transaction per core command,
// alignment check, resp watchdog, and sign/zero extension of load data.
`ifndef BUS_ACC_CNT
`define BUS_ACC_1B  0
`define BUS_ACC_2B  1
`define BUS_ACC_4B  2
`define BUS_ACC_CNT 3
`endif

module lsu_bus_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_wr,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0]    cmd_acc,
  input  logic                               cmd_signed,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [31:0]                        cmd_wdata,
  output logic                               done,
  output logic [31:0]                        done_rdata,
  output logic [1:0]                         done_err,
  output logic                               req,
  output logic [ADDR_WIDTH-1:0]              addr,
  output logic                               wr_b,
  output logic [$clog2(`BUS_ACC_CNT)-1:0]    acc,
  output logic [31:0]                        wdata,
  input  logic                               resp,
  input  logic [31:0]                        rdata,
  input  logic                               fault
);

  localparam int unsigned ACC_W   = $clog2(`BUS_ACC_CNT);
  localparam int unsigned ACC_CNT = `BUS_ACC_CNT;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [ACC_W-1:0] ACC_1B = ACC_W'(`BUS_ACC_1B);
  localparam logic [ACC_W-1:0] ACC_2B = ACC_W'(`BUS_ACC_2B);
  localparam logic [ACC_W-1:0] ACC_4B = ACC_W'(`BUS_ACC_4B);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_FAULT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    fault_q;
  logic                    signed_q;
  logic                    cmd_bad;
  logic [31:0]             wdata_masked;
  logic [31:0]             load_data;

  logic                    cmd_ready_nxt, req_nxt, done_nxt, wr_b_nxt;
  logic [1:0]              done_err_nxt;
  logic [31:0]             done_rdata_nxt, wdata_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [ACC_W-1:0]        acc_nxt;

  // Command is rejected for an unknown size code or an address not aligned to its size.
  always_comb begin
    cmd_bad = 1'b0;
    if (32'(cmd_acc) >= ACC_CNT)                          cmd_bad = 1'b1;
    else if (cmd_acc == ACC_2B && cmd_addr[0])            cmd_bad = 1'b1;
    else if (cmd_acc == ACC_4B && cmd_addr[1:0] != 2'b00) cmd_bad = 1'b1;
  end

  always_comb begin
    wdata_masked = cmd_wdata;
    if (cmd_acc == ACC_1B)      wdata_masked = {24'd0, cmd_wdata[7:0]};
    else if (cmd_acc == ACC_2B) wdata_masked = {16'd0, cmd_wdata[15:0]};
  end

  // Load extension uses the size held on the bus and the signedness latched at accept.
  always_comb begin
    load_data = rdata;
    if (acc == ACC_1B)      load_data = {{24{signed_q & rdata[7]}}, rdata[7:0]};
    else if (acc == ACC_2B) load_data = {{16{signed_q & rdata[15]}}, rdata[15:0]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid && cmd_ready) state_nxt = cmd_bad ? S_DONE : S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (resp || cnt == CNT_W'(TIMEOUT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered below.
  always_comb begin
    cmd_ready_nxt  = (state_nxt == S_IDLE);
    req_nxt        = (state_nxt == S_REQ);
    done_nxt       = (state_nxt == S_DONE);
    done_err_nxt   = ERR_OK;
    done_rdata_nxt = '0;
    addr_nxt       = addr;
    wr_b_nxt       = wr_b;
    acc_nxt        = acc;
    wdata_nxt      = wdata;
    case (state)
      S_IDLE: begin
        if (state_nxt == S_REQ) begin
          addr_nxt  = cmd_addr;
          wr_b_nxt  = cmd_wr;
          acc_nxt   = cmd_acc;
          wdata_nxt = wdata_masked;
        end else if (state_nxt == S_DONE) begin
          done_err_nxt = ERR_ALIGN;
        end
      end
      S_WAIT: begin
        if (resp) begin
          done_err_nxt = fault_q ? ERR_FAULT : ERR_OK;
          if (!fault_q && !wr_b) done_rdata_nxt = load_data;
        end else if (state_nxt == S_DONE) begin
          done_err_nxt = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_ready  <= 1'b0;
      req        <= 1'b0;
      done       <= 1'b0;
      done_err   <= ERR_OK;
      done_rdata <= '0;
      addr       <= '0;
      wr_b       <= 1'b0;
      acc        <= '0;
      wdata      <= '0;
      cnt        <= '0;
      fault_q    <= 1'b0;
      signed_q   <= 1'b0;
    end else begin
      cmd_ready  <= cmd_ready_nxt;
      req        <= req_nxt;
      done       <= done_nxt;
      done_err   <= done_err_nxt;
      done_rdata <= done_rdata_nxt;
      addr       <= addr_nxt;
      wr_b       <= wr_b_nxt;
      acc        <= acc_nxt;
      wdata      <= wdata_nxt;
      if (state == S_IDLE && cmd_valid && cmd_ready) signed_q <= cmd_signed;
      if (state == S_REQ) begin
        fault_q <= fault;
        cnt     <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Bench for lsu_bus_initiator: per-cycle expectations planned from each command's
// transaction-level outcome, compared against the DUT on every falling edge.
`ifndef BUS_ACC_CNT
`define BUS_ACC_1B  0
`define BUS_ACC_2B  1
`define BUS_ACC_4B  2
`define BUS_ACC_CNT 3
`endif

module tb_lsu_bus_initiator;
  localparam int unsigned TIMEOUT = 15;
  localparam int MAXC = 8192;
  localparam int AW = $clog2(`BUS_ACC_CNT);
  localparam logic [AW-1:0] A1B = AW'(`BUS_ACC_1B);
  localparam logic [AW-1:0] A2B = AW'(`BUS_ACC_2B);
  localparam logic [AW-1:0] A4B = AW'(`BUS_ACC_4B);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_signed = 1'b0;
  logic [AW-1:0] cmd_acc = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic cmd_ready, done, req, wr_b;
  logic [31:0] done_rdata, addr, wdata;
  logic [1:0] done_err;
  logic [AW-1:0] acc;
  logic resp = 1'b0, fault = 1'b0;
  logic [31:0] rdata = '0;

  lsu_bus_initiator #(.ADDR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_acc(cmd_acc), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .done_rdata(done_rdata), .done_err(done_err), .req(req), .addr(addr),
    .wr_b(wr_b), .acc(acc), .wdata(wdata), .resp(resp), .rdata(rdata), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle number.
  logic exp_ready [MAXC];
  logic exp_req   [MAXC];
  logic exp_done  [MAXC];
  logic exp_bus   [MAXC];
  logic exp_st    [MAXC];
  logic exp_rst   [MAXC];
  logic exp_wrb   [MAXC];
  logic [AW-1:0] exp_acc [MAXC];
  logic [1:0]  exp_err   [MAXC];
  logic [31:0] exp_addr  [MAXC];
  logic [31:0] exp_wdata [MAXC];
  logic [31:0] exp_rdata [MAXC];

  int checks = 0;
  int errors = 0;

  int obs_done_cyc = 0, obs_req_cyc = 0, obs_done_cnt = 0, obs_req_cnt = 0;
  logic [31:0] obs_rdata = '0, obs_wdata = '0, obs_addr = '0;
  logic [1:0] obs_err = '0;
  logic obs_wrb = 1'b0;
  logic [AW-1:0] obs_acc = '0;
  int last_acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready[cyc]));
      chk("req", 32'(req), 32'(exp_req[cyc]));
      chk("done", 32'(done), 32'(exp_done[cyc]));
      if (exp_done[cyc]) begin
        chk("done_err", 32'(done_err), 32'(exp_err[cyc]));
        chk("done_rdata", done_rdata, exp_rdata[cyc]);
      end
      if (exp_bus[cyc]) begin
        chk("addr", addr, exp_addr[cyc]);
        chk("wr_b", 32'(wr_b), 32'(exp_wrb[cyc]));
        chk("acc", 32'(acc), 32'(exp_acc[cyc]));
        if (exp_st[cyc]) chk("wdata", wdata, exp_wdata[cyc]);
      end
      if (exp_rst[cyc]) begin
        chk("rst_addr", addr, 32'd0);
        chk("rst_wr_b", 32'(wr_b), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_done_rdata", done_rdata, 32'd0);
      end
      if (done === 1'b1) begin
        obs_done_cyc = cyc; obs_err = done_err; obs_rdata = done_rdata; obs_done_cnt++;
      end
      if (req === 1'b1) begin
        obs_req_cyc = cyc; obs_addr = addr; obs_wdata = wdata; obs_wrb = wr_b; obs_acc = acc;
        obs_req_cnt++;
      end
    end
  end

  function automatic int unsigned acc_size(input logic [AW-1:0] a);
    if (a == A2B) return 2;
    if (a == A4B) return 4;
    return 1;
  endfunction

  function automatic logic model_bad(input logic [AW-1:0] a, input logic [31:0] ad);
    if (32'(a) >= 32'(`BUS_ACC_CNT)) return 1'b1;
    return (ad % acc_size(a)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic sgn,
                                             input logic [31:0] rd);
    int unsigned v;
    v = rd;
    if (a == A1B) begin
      v = rd % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (a == A2B) begin
      v = rd % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [AW-1:0] a, input logic [31:0] wd);
    int unsigned sz;
    sz = acc_size(a);
    if (sz == 4) return wd;
    return wd % (32'd1 << (8 * sz));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    resp  = 1'($urandom);
    fault = 1'($urandom);
    rdata = $urandom;
  endtask

  task automatic garbage_cmd();
    cmd_valid  = 1'($urandom);
    cmd_wr     = 1'($urandom);
    cmd_acc    = AW'($urandom);
    cmd_signed = 1'($urandom);
    cmd_addr   = $urandom;
    cmd_wdata  = $urandom;
  endtask

  task automatic idle(input int n, input logic force_resp);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      rand_bus();
      if (force_resp) resp = 1'b1;
      step();
    end
  endtask

  // Issue one command in the current (ready) cycle; lat=0 means the responder never answers.
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic sgn,
                        input logic [31:0] ad, input logic [31:0] wd, input int lat,
                        input logic flt, input logic [31:0] rd, input int rst_at);
    int A, R, D, X, last;
    A = cyc;
    last_acc_cyc = A;
    cmd_valid = 1'b1; cmd_wr = w; cmd_acc = a; cmd_signed = sgn; cmd_addr = ad; cmd_wdata = wd;
    rand_bus();
    if (model_bad(a, ad)) begin
      D = A + 1;
      exp_ready[D] = 1'b0; exp_done[D] = 1'b1; exp_err[D] = 2'd1; exp_rdata[D] = 32'd0;
      step();
      garbage_cmd(); rand_bus();
      step();
      return;
    end
    R = A + 1;
    D = (lat > 0) ? R + lat + 1 : R + int'(TIMEOUT) + 1;
    X = (rst_at > 0) ? R + rst_at : MAXC;
    exp_req[R] = 1'b1;
    for (int c = R; c <= D; c++) begin
      if (c < X) exp_ready[c] = 1'b0;
      if (c < D && c <= X) begin
        exp_bus[c] = 1'b1; exp_st[c] = w; exp_addr[c] = ad; exp_wrb[c] = w; exp_acc[c] = a;
        exp_wdata[c] = model_wdata(a, wd);
      end
    end
    if (X > D) begin
      exp_done[D] = 1'b1;
      if (lat == 0) begin
        exp_err[D] = 2'd3; exp_rdata[D] = 32'd0;
      end else begin
        exp_err[D]   = flt ? 2'd2 : 2'd0;
        exp_rdata[D] = (flt || w) ? 32'd0 : model_load(a, sgn, rd);
      end
      last = D;
    end else begin
      for (int c = X; c <= X + 2; c++) exp_ready[c] = 1'b0;
      exp_rst[X + 1] = 1'b1; exp_rst[X + 2] = 1'b1;
      last = X + 2;
    end
    step();
    for (int c = R; c <= last; c++) begin
      garbage_cmd();
      rand_bus();
      if (c > R && c < D && c <= X) begin
        resp = (lat > 0 && c == R + lat);
        if (resp) rdata = rd;
      end
      if (c == R) fault = flt;
      rstn = !(c == X || c == X + 1);
      step();
    end
    rstn = 1'b1;
  endtask

  initial begin
    int n_req, n_done, A, lat, rst_at;
    logic w, sgn, flt;
    logic [AW-1:0] a;
    logic [31:0] ad;
    for (int i = 0; i < MAXC; i++) begin
      exp_ready[i] = 1'b1; exp_req[i] = 1'b0; exp_done[i] = 1'b0; exp_bus[i] = 1'b0;
      exp_st[i] = 1'b0; exp_rst[i] = 1'b0; exp_wrb[i] = 1'b0; exp_acc[i] = '0;
      exp_err[i] = '0; exp_addr[i] = '0; exp_wdata[i] = '0; exp_rdata[i] = '0;
    end
    for (int i = 0; i <= 3; i++) exp_ready[i] = 1'b0;
    for (int i = 1; i <= 3; i++) exp_rst[i] = 1'b1;

    step();
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    step(); step();
    rstn = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_acc = A4B; cmd_addr = 32'h40;
    step();
    cmd_valid = 1'b0;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    do_cmd(1'b0, A4B, 1'b0, 32'h100, 32'h0, 1, 1'b0, 32'hDEADBEEF, 0);
    chk("lw_req_cycle", 32'(obs_req_cyc - last_acc_cyc), 32'd1);
    chk("lw_req_acc", 32'(obs_acc), 32'(A4B));
    chk("lw_req_wr", 32'(obs_wrb), 32'd0);
    chk("lw_done_cycle", 32'(obs_done_cyc - last_acc_cyc), 32'd3);
    chk("lw_rdata", obs_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(obs_err), 32'd0);
    chk("lw_ready_again", 32'(cmd_ready), 32'd1);

    do_cmd(1'b0, A1B, 1'b1, 32'h103, 32'h0, 1, 1'b0, 32'h00000080, 0);
    chk("lb_signed", obs_rdata, 32'hFFFFFF80);
    do_cmd(1'b0, A1B, 1'b0, 32'h103, 32'h0, 1, 1'b0, 32'h00000080, 0);
    chk("lb_unsigned", obs_rdata, 32'h00000080);
    do_cmd(1'b0, A2B, 1'b1, 32'h102, 32'h0, 1, 1'b0, 32'h00007FFF, 0);
    chk("lh_signed_pos", obs_rdata, 32'h00007FFF);

    do_cmd(1'b1, A2B, 1'b0, 32'h102, 32'h12345678, 1, 1'b1, 32'hFFFFFFFF, 0);
    chk("sh_wr_b", 32'(obs_wrb), 32'd1);
    chk("sh_wdata", obs_wdata, 32'h00005678);
    chk("sh_err", 32'(obs_err), 32'd2);
    chk("sh_rdata", obs_rdata, 32'd0);

    n_req = obs_req_cnt;
    do_cmd(1'b0, A4B, 1'b0, 32'h102, 32'h0, 1, 1'b0, 32'h0, 0);
    chk("mis4_no_req", 32'(obs_req_cnt - n_req), 32'd0);
    chk("mis4_err", 32'(obs_err), 32'd1);
    chk("mis4_done_cycle", 32'(obs_done_cyc - last_acc_cyc), 32'd1);
    do_cmd(1'b0, A2B, 1'b0, 32'h101, 32'h0, 1, 1'b0, 32'h0, 0);
    chk("mis2_no_req", 32'(obs_req_cnt - n_req), 32'd0);
    chk("mis2_err", 32'(obs_err), 32'd1);

    do_cmd(1'b0, A4B, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'h0, 0);
    chk("to_done_cycle", 32'(obs_done_cyc - (last_acc_cyc + 1)), 32'd16);
    chk("to_err", 32'(obs_err), 32'd3);
    n_done = obs_done_cnt;
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("late_resp_ignored", 32'(obs_done_cnt - n_done), 32'd0);
    do_cmd(1'b0, A4B, 1'b0, 32'h104, 32'h0, 3, 1'b0, 32'hCAFEF00D, 0);
    chk("after_to_rdata", obs_rdata, 32'hCAFEF00D);
    chk("after_to_err", 32'(obs_err), 32'd0);

    do_cmd(1'b0, A2B, 1'b0, 32'h106, 32'h0, int'(TIMEOUT), 1'b0, 32'h0000ABCD, 0);
    chk("resp_at_limit_err", 32'(obs_err), 32'd0);
    chk("resp_at_limit_rdata", obs_rdata, 32'h0000ABCD);

    n_req = obs_req_cnt; n_done = obs_done_cnt;
    do_cmd(1'b0, A4B, 1'b0, 32'h200, 32'h0, 0, 1'b0, 32'h0, 3);
    chk("rst_ready_first", 32'(cmd_ready), 32'd1);
    idle(2, 1'b1);
    chk("rst_no_done", 32'(obs_done_cnt - n_done), 32'd0);
    chk("rst_one_req", 32'(obs_req_cnt - n_req), 32'd1);

    for (int k = 0; k < 250 && cyc < MAXC - 64; k++) begin
      w   = 1'($urandom);
      sgn = 1'($urandom);
      a   = ($urandom % 8 == 0) ? AW'(3) : AW'($urandom_range(2, 0));
      ad  = $urandom;
      if ($urandom % 4 != 0) ad = ad - (ad % acc_size(a));
      case ($urandom % 10)
        0:       lat = 0;
        1:       lat = int'(TIMEOUT);
        2, 3, 4: lat = 1;
        default: lat = int'($urandom_range(TIMEOUT, 1));
      endcase
      flt    = ($urandom % 4 == 0);
      rst_at = (lat == 0 && $urandom % 3 == 0) ? int'($urandom_range(TIMEOUT, 1)) : 0;
      A = int'($urandom % 3);
      if (A > 0) idle(A, 1'b0);
      do_cmd(w, a, sgn, ad, $urandom, lat, flt, $urandom, rst_at);
    end
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_initiator.md
Name: lsu_bus_initiator

Overview:
- Bus initiator (master end) of the femto req/resp memory bus.
- Accepts load/store commands from the core, checks alignment, and issues one bus transaction per command.
- Waits for resp with a timeout watchdog, then extracts and sign/zero-extends load data.
- Reports a single completion pulse with an error code. Sits between the core's LSU stage and the bus fabric (ROM, RAM, peripherals).

Parameters:
- ADDR_WIDTH, 32, byte address width on both the command side and the bus side.
- TIMEOUT, 15, maximum number of cycles after the req cycle to wait for resp (must be >=1).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_wr  in  1  1=store, 0=load
- cmd_acc  in  $clog2(`BUS_ACC_CNT)  access size; `BUS_ACC_1B/`BUS_ACC_2B/`BUS_ACC_4B encodings
- cmd_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  store data, right-justified
- done  out  1  one-cycle completion pulse
- done_rdata  out  32  extended load data; valid while done=1
- done_err  out  2  completion code: 0=ok, 1=misaligned/invalid acc, 2=bus fault, 3=timeout
- req  out  1  bus request, one-cycle pulse
- addr  out  ADDR_WIDTH  bus byte address
- wr_b  out  1  bus write flag
- acc  out  $clog2(`BUS_ACC_CNT)  bus access size
- wdata  out  32  bus write data, right-justified, bits above the access size zeroed
- resp  in  1  responder completion; rdata valid in this cycle
- rdata  in  32  responder read data, right-justified
- fault  in  1  responder fault; valid in the req cycle only

Behaviour:
- All outputs registered. Reset values:
  - cmd_ready=0 during reset, 1 in the first cycle after reset.
  - done=0, done_rdata=0, done_err=0.
  - req=0, addr=0, wr_b=0, acc=0, wdata=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE (cmd_ready=1): on cmd_valid, latch the command.
  - Misaligned = 2B with addr[0]=1, or 4B with addr[1:0]!=0. Invalid acc = code >= `BUS_ACC_CNT.
  - Misaligned or invalid: go to DONE with err=1; req is never asserted.
  - Otherwise: go to REQ.
- REQ: req=1 for exactly this cycle, with addr/wr_b/acc/wdata driven.
  - Sample fault into a sticky flag.
  - Clear the timeout counter; go to WAIT.
- WAIT: req=0; bus address/control outputs hold their values.
  - resp=1: capture rdata; go to DONE. err=2 if the fault flag is set, else 0.
  - resp=0: counter increments. When the counter reaches TIMEOUT, go to DONE with err=3.
  - resp in the same cycle the counter reaches TIMEOUT: resp wins, err=0/2.
- DONE: done=1 for one cycle, then return to IDLE. cmd_ready=0 in REQ, WAIT and DONE.
- Load data extraction:
  - 1B: rdata[7:0] extended by cmd_signed.
  - 2B: rdata[15:0] extended by cmd_signed.
  - 4B: rdata unchanged.
- done_rdata is 0 for stores and for any err!=0.
- Latency with a 1-cycle responder: cmd accepted cycle 0, req cycle 1, resp cycle 2, done cycle 3, cmd_ready=1 cycle 4. Throughput is one command per 4 cycles.
- Misaligned command: accepted cycle 0, done cycle 1 with err=1.
- A resp arriving in IDLE, REQ or DONE (late response after a timeout) is ignored and not attributed to any command.
- Reset asserted mid-transaction: state returns to IDLE, all outputs take their reset values, no done is issued, and the counter and fault flag clear.

Test Plan:
- Load 4B addr 0x100, 1-cycle responder returns rdata=0xDEADBEEF -> req pulse at cycle 1 with acc=4B, wr_b=0; done at cycle 3, done_rdata=0xDEADBEEF, err=0.
- Load 1B signed addr 0x103, rdata=0x00000080 -> done_rdata=0xFFFFFF80. Same access unsigned -> 0x00000080. Load 2B signed, rdata=0x00007FFF -> 0x00007FFF.
- Store 2B addr 0x102, cmd_wdata=0x12345678, responder asserts fault in the req cycle, resp one cycle later -> wr_b=1, wdata=0x00005678, done err=2, done_rdata=0.
- Load 4B addr 0x102 -> no req ever; done one cycle after accept with err=1. Load 2B addr 0x101 -> same result.
- Responder never answers, TIMEOUT=15 -> done err=3 exactly 16 cycles after the req cycle. A resp injected 2 cycles later in IDLE -> no done; the next command completes normally.
- Reset pulsed during WAIT -> req/done stay 0, cmd_ready=1 in the first cycle after reset. A resp arriving after reset is ignored.
